// File: rtl/lsu_access_sequencer.sv
// Load/store sequencer between the MEM stage and a word-organised data memory.
// Word-crossing accesses are split into two aligned beats, or rejected when splitting is disabled.
module lsu_access_sequencer #(
    parameter int ADDR_WIDTH       = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  misaligned_err,
    output logic                  stall,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        cross_q;
    logic [31:0] lo_buf;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Byte enables and data spread over two words: [3:0]/[31:0] is beat 0, the upper half is beat 1.
    function automatic logic [7:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        return {4'b0000, size_mask(size)} << off;
    endfunction

    function automatic logic [63:0] lane_data(input logic [31:0] wdata, input logic [1:0] off);
        return {32'h0, wdata} << {off, 3'b000};
    endfunction

    function automatic logic [31:0] extend(input logic [63:0] pair, input logic [1:0] off,
                                           input logic [2:0] funct3);
        logic [31:0] raw;
        raw = 32'(pair >> {off, 3'b000});
        case (funct3[1:0])
            2'b00:   return {{24{raw[7]  & ~funct3[2]}}, raw[7:0]};
            2'b01:   return {{16{raw[15] & ~funct3[2]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    logic req_cross;
    logic req_reject;
    assign req_cross  = ({1'b0, req_addr[1:0]} + size_bytes(req_funct3[1:0])) > 3'd4;
    assign req_reject = (req_funct3[1:0] == 2'b11) || (req_cross && !SPLIT_MISALIGNED);

    // NOTE: every register here is assigned with <= so all updates take effect together at the edge;
    // a blocking assignment would let later statements see the new value and change the logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            funct3_q       <= 3'b000;
            off_q          <= 2'b00;
            wdata_q        <= 32'h0;
            cross_q        <= 1'b0;
            lo_buf         <= 32'h0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'h0;
            misaligned_err <= 1'b0;
            stall          <= 1'b0;
            mem_valid      <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= 4'b0000;
            mem_wdata      <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        cross_q   <= req_cross;
                        req_ready <= 1'b0;
                        if (req_reject) begin
                            state          <= RESP;
                            resp_valid     <= 1'b1;
                            misaligned_err <= 1'b1;
                            resp_rdata     <= 32'h0;
                        end else begin
                            state     <= BEAT0;
                            stall     <= 1'b1;
                            mem_valid <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_be    <= req_we ? 4'(lane_be(req_funct3[1:0], req_addr[1:0])) : 4'b1111;
                            mem_wdata <= 32'(lane_data(req_wdata, req_addr[1:0]));
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        lo_buf <= mem_rdata;
                        if (cross_q) begin
                            state     <= BEAT1;
                            mem_addr  <= mem_addr + ADDR_WIDTH'(4);
                            mem_be    <= we_q ? 4'(lane_be(funct3_q[1:0], off_q) >> 4) : 4'b1111;
                            mem_wdata <= 32'(lane_data(wdata_q, off_q) >> 32);
                        end else begin
                            state      <= RESP;
                            mem_valid  <= 1'b0;
                            stall      <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_rdata <= we_q ? 32'h0 : extend({32'h0, mem_rdata}, off_q, funct3_q);
                        end
                    end
                end
                BEAT1: begin
                    // The high word is consumed straight from the bus, so it never needs its own buffer.
                    if (mem_ready) begin
                        state      <= RESP;
                        mem_valid  <= 1'b0;
                        stall      <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= we_q ? 32'h0 : extend({mem_rdata, lo_buf}, off_q, funct3_q);
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    req_ready      <= 1'b1;
                    resp_valid     <= 1'b0;
                    resp_rdata     <= 32'h0;
                    misaligned_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// Randomised bench for lsu_access_sequencer against a byte-level memory model.
// A second instance with splitting disabled covers the reject path.
module tb_lsu_access_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_we = 0, mem_ready = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
    logic        req_ready, resp_valid, misaligned_err, stall, mem_valid, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        n_req_valid = 0, n_req_we = 0;
    logic [2:0]  n_req_funct3 = 0;
    logic [31:0] n_req_addr = 0, n_req_wdata = 0;
    logic        n_req_ready, n_resp_valid, n_misaligned_err, n_stall, n_mem_valid, n_mem_we;
    logic [31:0] n_resp_rdata, n_mem_addr, n_mem_wdata;
    logic [3:0]  n_mem_be;

    lsu_access_sequencer #(.ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misaligned_err(misaligned_err),
        .stall(stall), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

    lsu_access_sequencer #(.ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we),
        .req_funct3(n_req_funct3), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
        .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata), .misaligned_err(n_misaligned_err),
        .stall(n_stall), .mem_valid(n_mem_valid), .mem_ready(1'b1), .mem_we(n_mem_we),
        .mem_addr(n_mem_addr), .mem_be(n_mem_be), .mem_wdata(n_mem_wdata), .mem_rdata(32'h0));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    bit [7:0] bmem [bit [31:0]];

    function automatic bit [7:0] rd_byte(input bit [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic bit [31:0] rd_word(input bit [31:0] a);
        return {rd_byte(a + 3), rd_byte(a + 2), rd_byte(a + 1), rd_byte(a)};
    endfunction

    function automatic bit [31:0] expand(input bit [3:0] be);
        bit [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // ready_mode: 0 random ready, 1 ready always, 2 ready low for the first three beat cycles.
    task automatic run_access(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                              input bit [31:0] wdata, input int ready_mode, input bit abort);
        int nb, n, k, b, g, lane;
        bit illegal, done, rdy;
        bit [31:0] exp_addr [2];
        bit [3:0]  exp_be [2];
        bit [31:0] exp_wd [2];
        bit [31:0] exp_rd, ba, w;

        illegal = (f3[1:0] == 2'b11);
        n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        nb = 0;
        exp_addr = '{0, 0}; exp_be = '{0, 0}; exp_wd = '{0, 0}; exp_rd = 0;
        if (!illegal) begin
            for (int j = 0; j < n; j++) begin
                ba   = addr + j;
                w    = {ba[31:2], 2'b00};
                lane = int'(ba[1:0]);
                if (nb == 0 || w != exp_addr[nb-1]) begin
                    exp_addr[nb] = w;
                    nb++;
                end
                exp_be[nb-1][lane] = 1'b1;
                exp_wd[nb-1][8*lane +: 8] = wdata[8*j +: 8];
                if (!we) exp_rd[8*j +: 8] = rd_byte(ba);
            end
            if (!we) begin
                exp_be = '{4'hF, 4'hF};
                if (!f3[2] && n < 4 && exp_rd[8*n-1])
                    for (int j = n; j < 4; j++) exp_rd[8*j +: 8] = 8'hFF;
            end
        end

        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("req_ready_wait", req_ready, 1);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 0;
        k = 1; b = 0; done = 0;
        while (!done && k <= 60) begin
            if (abort && k == 4) begin
                rst_n = 0;
                #1;
                check("rst_mem_valid", mem_valid, 0);
                check("rst_resp_valid", resp_valid, 0);
                check("rst_stall", stall, 0);
                check("rst_req_ready", req_ready, 1);
                check("rst_mem_addr", mem_addr, 0);
                check("rst_mem_be", mem_be, 0);
                mem_ready = 0;
                @(negedge clk);
                rst_n = 1;
                @(negedge clk);
                return;
            end
            if (resp_valid) begin
                if (ready_mode == 1) check("latency", k, illegal ? 1 : nb + 1);
                check("resp_rdata", resp_rdata, exp_rd);
                check("misaligned_err", misaligned_err, illegal);
                check("stall_at_resp", stall, 0);
                check("beat_count", b, nb);
                done = 1;
                mem_ready = 0;
            end else begin
                check("stall_busy", stall, 1);
                check("req_ready_busy", req_ready, 0);
                check("mem_valid_busy", mem_valid, 1);
                if (mem_valid) begin
                    if (b >= nb) begin
                        check("extra_beat", b, nb);
                    end else begin
                        check("mem_addr", mem_addr, exp_addr[b]);
                        check("mem_be", mem_be, exp_be[b]);
                        check("mem_we", mem_we, we);
                        if (we) check("mem_wdata", mem_wdata & expand(exp_be[b]), exp_wd[b]);
                    end
                    case (ready_mode)
                        0:       rdy = ($urandom_range(0, 2) != 0);
                        1:       rdy = 1;
                        default: rdy = (k > 3);
                    endcase
                    mem_ready = rdy;
                    mem_rdata = rd_word(mem_addr);
                    if (rdy) begin
                        if (mem_we)
                            for (int i = 0; i < 4; i++)
                                if (mem_be[i]) bmem[mem_addr + i] = mem_wdata[8*i +: 8];
                        b++;
                    end
                end else begin
                    mem_ready = 0;
                end
                @(negedge clk);
                k++;
            end
        end
        if (!done) check("resp_timeout", 0, 1);
    endtask

    task automatic ns_access(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit exp_err);
        int k;
        bit done, saw_beat;
        k = 0;
        while (!n_req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_req_valid = 1; n_req_we = we; n_req_funct3 = f3; n_req_addr = addr; n_req_wdata = 32'h55AA_1234;
        @(negedge clk);
        n_req_valid = 0;
        k = 1; done = 0; saw_beat = 0;
        while (!done && k <= 20) begin
            if (n_mem_valid) saw_beat = 1;
            if (n_resp_valid) begin
                check("ns_latency", k, exp_err ? 1 : 2);
                check("ns_err", n_misaligned_err, exp_err);
                check("ns_beat_seen", saw_beat, !exp_err);
                done = 1;
            end
            @(negedge clk);
            k++;
        end
        if (!done) check("ns_timeout", 0, 1);
    endtask

    initial begin
        bit [2:0]  f3;
        bit [31:0] a;
        bit        we;
        repeat (2) @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_stall", stall, 0);
        check("reset_mem_valid", mem_valid, 0);
        check("reset_err", misaligned_err, 0);
        check("reset_resp_rdata", resp_rdata, 0);
        rst_n = 1;
        @(negedge clk);

        run_access(1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 0);
        run_access(1, 3'b000, 32'h203, 32'h000000A5, 1, 0);
        run_access(1, 3'b001, 32'h103, 32'h00001234, 1, 0);
        bmem[32'h103] = 8'h80;
        bmem[32'h104] = 8'hFF;
        run_access(0, 3'b001, 32'h103, 0, 1, 0);
        check("lh_value", resp_rdata, 32'hFFFFFF80);
        run_access(0, 3'b101, 32'h103, 0, 1, 0);
        run_access(0, 3'b011, 32'h100, 0, 1, 0);
        run_access(0, 3'b010, 32'hFFFF_FFFE, 0, 1, 0);
        run_access(1, 3'b010, 32'hFFFF_FFFD, 32'hCAFEF00D, 0, 0);
        run_access(0, 3'b010, 32'h200, 0, 2, 1);

        ns_access(1, 3'b010, 32'h102, 1);
        ns_access(0, 3'b001, 32'h103, 1);
        ns_access(0, 3'b010, 32'h100, 0);

        for (int t = 0; t < 300; t++) begin
            we = $urandom_range(0, 1);
            f3[1:0] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            f3[2]   = we ? 1'b0 : 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 + $urandom_range(0, 7))
                                            : (32'h1000 + $urandom_range(0, 63));
            run_access(we, f3, a, $urandom, $urandom_range(0, 1), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
